// File: rtl/dac_serial_drv.sv
// rtl/dac_serial_drv.sv - TLC5615-style 3-wire serial DAC driver
// Shifts 10-bit samples MSB first plus two zero sub-LSBs; CS rise latches the word.
module dac_serial_drv #(
   parameter int CLK_DIV = 2,
   parameter int GAP_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [9:0] wave_data,
   output logic       dac_cs_n,
   output logic       dac_sclk,
   output logic       dac_din,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_TC = 8'(GAP_CYC - 1);

   state_t      state_q, state_d;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [11:0] sh_q, sh_d;
   logic        cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        din_q, din_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         div_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         sh_q         <= '0;
         cs_n_q       <= 1'b1;
         sclk_q       <= 1'b0;
         din_q        <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         sh_q         <= sh_d;
         cs_n_q       <= cs_n_d;
         sclk_q       <= sclk_d;
         din_q        <= din_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      sh_d         = sh_q;
      cs_n_d       = cs_n_q;
      sclk_d       = sclk_q;
      din_d        = din_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               sh_d      = {wave_data, 2'b00};
               cs_n_d    = 1'b0;
               din_d     = wave_data[9];
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               div_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (div_cnt_q == DIV_TC) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else if (bit_cnt_q < 4'd11) begin
                  // data only moves on the falling edge so the DAC sees a stable bit at rise
                  sclk_d    = 1'b0;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  sh_d      = {sh_q[10:0], 1'b0};
                  din_d     = sh_q[10];
               end else begin
                  sclk_d       = 1'b0;
                  cs_n_d       = 1'b1;
                  frame_done_d = 1'b1;
                  din_d        = 1'b0;
                  gap_cnt_d    = '0;
                  state_d      = GAP;
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_TC) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dac_cs_n   = cs_n_q;
   assign dac_sclk   = sclk_q;
   assign dac_din    = din_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_serial_drv.sv
// tb/tb_dac_serial_drv.sv - directed bench for dac_serial_drv
// u1 uses default timing, u2 the fastest legal timing; observations are taken on clk falling edges.
module tb_dac_serial_drv;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en1 = 1'b0;
   logic       en2 = 1'b0;
   logic [9:0] wave = '0;
   logic       cs1, sclk1, din1, busy1, fd1;
   logic       cs2, sclk2, din2, busy2, fd2;
   logic       sel = 1'b0;
   logic       m_cs, m_sclk, m_din, m_busy, m_fd;

   int checks = 0;
   int errors = 0;
   int n_rise, n_cslow, n_busy, n_fd, n_sclk_hi, frame_rises;
   int fall_at[$];
   logic [11:0] bits, first_word;
   logic [9:0]  exp_word;
   logic        step_wave = 1'b0;

   always #5 clk = ~clk;

   dac_serial_drv u1 (
      .clk(clk), .rst(rst), .en(en1), .wave_data(wave),
      .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_din(din1), .busy(busy1), .frame_done(fd1)
   );

   dac_serial_drv #(.CLK_DIV(1), .GAP_CYC(1)) u2 (
      .clk(clk), .rst(rst), .en(en2), .wave_data(wave),
      .dac_cs_n(cs2), .dac_sclk(sclk2), .dac_din(din2), .busy(busy2), .frame_done(fd2)
   );

   assign m_cs   = sel ? cs2   : cs1;
   assign m_sclk = sel ? sclk2 : sclk1;
   assign m_din  = sel ? din2  : din1;
   assign m_busy = sel ? busy2 : busy1;
   assign m_fd   = sel ? fd2   : fd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample ncyc falling edges; drop the selected enable at cycle drop_cyc or on rise drop_rise.
   task automatic observe(input int ncyc, input int drop_cyc, input int drop_rise);
      logic sclk_p, cs_p;
      n_rise = 0; n_cslow = 0; n_busy = 0; n_fd = 0; n_sclk_hi = 0; frame_rises = 0;
      bits = '0; first_word = '0; exp_word = '0;
      fall_at.delete();
      sclk_p = m_sclk;
      cs_p   = m_cs;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (cs_p && !m_cs) begin
            fall_at.push_back(i);
            exp_word    = wave;
            frame_rises = 0;
         end
         if (!m_cs)  n_cslow++;
         if (m_busy) n_busy++;
         if (m_fd)   n_fd++;
         if (m_sclk) n_sclk_hi++;
         if (!sclk_p && m_sclk) begin
            n_rise++;
            frame_rises++;
            bits = {bits[10:0], m_din};
            if (n_rise == 12) first_word = bits;
            if (step_wave && frame_rises == 12) chk("stream_word", 32'(bits), 32'({exp_word, 2'b00}));
         end
         if (i == drop_cyc || n_rise == drop_rise) begin
            if (sel) en2 = 1'b0;
            else     en1 = 1'b0;
         end
         if (step_wave) wave = wave + 10'd1;
         sclk_p = m_sclk;
         cs_p   = m_cs;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && m_busy; k++) @(negedge clk);
      chk("drain_busy", 32'(m_busy), 32'd0);
   endtask

   initial begin
      // reset state
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_cs_n", 32'(cs1), 32'd1);
      chk("rst_sclk", 32'(sclk1), 32'd0);
      chk("rst_din", 32'(din1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_fd", 32'(fd1), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // idle with en low
      observe(100, -1, -1);
      chk("idle_cslow", 32'(n_cslow), 32'd0);
      chk("idle_sclk_hi", 32'(n_sclk_hi), 32'd0);
      chk("idle_busy", 32'(n_busy), 32'd0);
      chk("idle_fd", 32'(n_fd), 32'd0);

      // single frame, en pulsed for one cycle
      wave = 10'h2A5;
      en1  = 1'b1;
      observe(80, 0, -1);
      chk("single_fall_cnt", 32'(fall_at.size()), 32'd1);
      chk("single_latency", 32'(fall_at.size() > 0 ? fall_at[0] : -1), 32'd0);
      chk("single_rises", 32'(n_rise), 32'd12);
      chk("single_bits", 32'(first_word), 32'b101010010100);
      chk("single_cslow", 32'(n_cslow), 32'd48);
      chk("single_busy", 32'(n_busy), 32'd52);
      chk("single_fd", 32'(n_fd), 32'd1);

      // continuous frames with a stepping sample stream
      wave      = 10'd0;
      en1       = 1'b1;
      step_wave = 1'b1;
      observe(170, -1, -1);
      step_wave = 1'b0;
      en1       = 1'b0;
      chk("stream_falls", 32'(fall_at.size()), 32'd4);
      for (int f = 1; f < fall_at.size(); f++)
         chk("stream_period", 32'(fall_at[f] - fall_at[f-1]), 32'd53);
      drain();

      // fastest timing instance
      sel  = 1'b1;
      wave = 10'h3FF;
      en2  = 1'b1;
      observe(52, -1, -1);
      en2 = 1'b0;
      chk("fast_falls", 32'(fall_at.size()), 32'd2);
      chk("fast_period", 32'(fall_at.size() == 2 ? fall_at[1] - fall_at[0] : -1), 32'd26);
      chk("fast_rises", 32'(n_rise), 32'd24);
      chk("fast_cslow", 32'(n_cslow), 32'd48);
      chk("fast_bits", 32'(first_word), 32'hFFC);
      chk("fast_fd", 32'(n_fd), 32'd2);
      drain();
      sel = 1'b0;

      // en dropped mid-frame at bit 5
      wave = 10'h0F0;
      en1  = 1'b1;
      observe(150, -1, 5);
      chk("drop_falls", 32'(fall_at.size()), 32'd1);
      chk("drop_rises", 32'(n_rise), 32'd12);
      chk("drop_fd", 32'(n_fd), 32'd1);
      chk("drop_bits", 32'(first_word), 32'h3C0);
      chk("drop_idle_cs", 32'(cs1), 32'd1);
      chk("drop_idle_busy", 32'(busy1), 32'd0);

      // asynchronous reset while sclk is high
      en1 = 1'b1;
      for (int k = 0; k < 20 && !sclk1; k++) @(negedge clk);
      chk("arst_sclk_pre", 32'(sclk1), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_cs_n", 32'(cs1), 32'd1);
      chk("arst_sclk", 32'(sclk1), 32'd0);
      chk("arst_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      wave = 10'h155;
      rst  = 1'b0;
      observe(53, -1, -1);
      en1 = 1'b0;
      chk("arst_latency", 32'(fall_at.size() > 0 ? fall_at[0] : -1), 32'd0);
      chk("arst_rises", 32'(n_rise), 32'd12);
      chk("arst_bits", 32'(first_word), 32'h554);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
